sdram_access_engine: RTL
========================

Name: sdram_access_engine

Overview:
- Runtime SDRAM command engine that sits directly downstream of the SDRAM power-up/init sequencer.
- After `init_done` it owns the SDRAM command/address/data pins and serves single-word (burst length 1, CAS 3) read/write requests from a client port.
- Issues periodic auto-refresh. Every access uses READ/WRITE with auto-precharge, so no row is left open.
- The top level muxes the pins: the init sequencer drives them while `init_done`=0, this block drives them afterwards. CS_n=0 and CKE=1 are held by the top level.

Parameters:
- T_RCD, 3, ACTIVE-to-READ/WRITE delay in clocks (18 ns at 166 MHz).
- CAS_LATENCY, 3, must match the mode register loaded by the init sequencer.
- T_RP, 3, precharge time in clocks.
- T_WR, 2, write recovery in clocks before auto-precharge starts.
- T_RFC, 10, AUTO REFRESH to next command, in clocks.
- REFRESH_INTERVAL, 1200, clocks between refreshes (< 7.8 us at 166 MHz).

Ports:
- dram_clk  input  1  SDRAM clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high.
- init_done  input  1  level from init sequencer; high once its READY state is reached.
- req_valid  input  1  client request present.
- req_ready  output  1  engine accepts request this cycle.
- req_write  input  1  1=write, 0=read.
- req_addr  input  22  {bank[1:0], row[11:0], col[7:0]} word address.
- req_wdata  input  16  write data.
- req_be  input  2  byte enables {upper, lower}, active-high.
- rd_valid  output  1  one-cycle pulse, rd_data valid.
- rd_data  output  16  read data.
- dram_cmd  output  3  {ras_n, cas_n, we_n}.
- dram_addr  output  12  SDRAM address.
- dram_ba  output  2  bank address.
- dram_dqm  output  2  {udqm, ldqm}.
- dram_dq_out  output  16  write data to pad.
- dram_dq_oe  output  1  pad output enable.
- dram_dq_in  input  16  data from pad.

Behaviour:
- Reset values:
  - dram_cmd=NOP (3'b111); dram_addr=0; dram_ba=0; dram_dqm=2'b11; dram_dq_oe=0; dram_dq_out=0.
  - req_ready=0; rd_valid=0; rd_data=0.
  - Refresh counter=0; state=IDLE.
- Registering: all pin outputs are registered (fast output registers). dram_dq_in is captured in an input register, so read data returns CAS_LATENCY+1 clocks after the READ command cycle.
- While init_done=0: state is held in IDLE, outputs stay at reset values, and the refresh counter does not run.
- Refresh counter:
  - Free-running from 0 once init_done=1.
  - On reaching REFRESH_INTERVAL-1 it sets refresh_pending and wraps to 0.
  - refresh_pending clears when AUTO REFRESH is issued.
- State machine:
  - IDLE:
    - If refresh_pending: go to REFRESH. Refresh wins over a simultaneous req_valid.
    - Else req_ready=1. On req_valid&&req_ready: latch the request, issue ACTIVE (ba=bank, addr=row), go to WAIT_RCD.
    - req_ready is a registered output, high only in IDLE with init_done=1 and no refresh pending.
  - WAIT_RCD: NOP for T_RCD-1 clocks.
    - Write: go to WRITE.
    - Read: go to READ.
  - WRITE: issue CMD_WRITE with addr={1'b0, A10=1, 2'b00, col}, dq_oe=1, dq_out=wdata, dqm=~be. Then NOP for T_WR+T_RP clocks, dq_oe=0, dqm=2'b11, then IDLE.
  - READ: issue CMD_READ with A10=1, dqm=2'b00. Then NOP.
    - Capture dram_dq_in CAS_LATENCY clocks after READ into rd_data; assert rd_valid for exactly one clock at READ+CAS_LATENCY+1.
    - Return to IDLE after max(CAS_LATENCY+1, T_RP) clocks.
  - REFRESH: issue AUTO_REFRESH (3'b001), then NOP for T_RFC-1 clocks, then IDLE.
- Timing:
  - Access latency: one request is accepted per access.
  - Read turnaround: IDLE→IDLE is 1+T_RCD+1+max(CAS_LATENCY+1, T_RP) clocks.
  - Write turnaround: IDLE→IDLE is 1+T_RCD+1+T_WR+T_RP clocks.
- Refresh during an access: the in-flight access completes first; refresh follows in the next IDLE. Worst-case delay is less than 20 clocks, which stays within the refresh budget.
- init_done falling mid-operation: not supported. Only reset recovers.
- Reset mid-access: aborts immediately; pins return to NOP/dqm=11/oe=0 on the next clock. No rd_valid is emitted for the aborted read.
- Address mapping: fixed, no wrap logic; req_addr is used as-is.
- One wait counter (5 bits) is shared by all timed states.

Decomposition:
- Shared package sdram_pkg: CMD_* 3-bit encodings (LOAD_MODE 000, AUTO_REFRESH 001, PRECHARGE 010, ACTIVE 011, WRITE 100, READ 101, BURST_TERMINATE 110, NOP 111), timing defaults, address field widths. Used by the init sequencer and this block.
- One sub-module, sdram_refresh_timer: counter plus refresh_pending flag with clear input.

Test Plan:
- Reset held with init_done=1 → all outputs at reset values; req_ready=0; no refresh issued.
- init_done=1, write addr 0x2_0A5_3C, data 0xBEEF, be=11 → ACTIVE ba=2 row=0x0A5; WRITE 3 clocks later, addr=0x43C, dq_oe=1, dqm=00; req_ready high again after T_WR+T_RP.
- Read same address, memory model returns 0xBEEF → READ with A10=1; rd_valid single pulse 4 clocks after READ; rd_data=0xBEEF.
- Write be=01 → dqm=2'b10 on the WRITE cycle only.
- Idle for 5000 clocks → AUTO_REFRESH issued every 1200 clocks (±access delay); ≥T_RFC NOPs follow each.
- req_valid asserted on the cycle refresh_pending sets → AUTO_REFRESH first; ACTIVE no earlier than T_RFC clocks later. Then pulse reset mid-read → no rd_valid; pins at NOP next cycle.

Source files
------------

// File: rtl/sdram_pkg.sv
// rtl/sdram_pkg.sv - shared SDRAM command encodings, timing defaults and field widths
//
// Used by the init sequencer and the runtime access engine.
//   CMD_*      : {ras_n, cas_n, we_n} command encodings
//   *_DEF      : default timing parameters in dram_clk cycles
//   *_W        : address, data and counter field widths
//   eng_state_t: access engine state encoding
//   eng_req_t  : request fields held for the duration of one access
package sdram_pkg;

    localparam logic [2:0] CMD_LOAD_MODE       = 3'b000;
    localparam logic [2:0] CMD_AUTO_REFRESH    = 3'b001;
    localparam logic [2:0] CMD_PRECHARGE       = 3'b010;
    localparam logic [2:0] CMD_ACTIVE          = 3'b011;
    localparam logic [2:0] CMD_WRITE           = 3'b100;
    localparam logic [2:0] CMD_READ            = 3'b101;
    localparam logic [2:0] CMD_BURST_TERMINATE = 3'b110;
    localparam logic [2:0] CMD_NOP             = 3'b111;

    localparam int T_RCD_DEF            = 3;
    localparam int CAS_LATENCY_DEF      = 3;
    localparam int T_RP_DEF             = 3;
    localparam int T_WR_DEF             = 2;
    localparam int T_RFC_DEF            = 10;
    localparam int REFRESH_INTERVAL_DEF = 1200;

    localparam int BANK_W = 2;
    localparam int ROW_W  = 12;
    localparam int COL_W  = 8;
    localparam int ADDR_W = BANK_W + ROW_W + COL_W;
    localparam int DQ_W   = 16;
    localparam int DQM_W  = 2;
    localparam int WAIT_W = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_RCD,
        ST_WRITE,
        ST_WRITE_REC,
        ST_READ,
        ST_READ_WAIT,
        ST_REFRESH
    } eng_state_t;

    // Bank and row go straight to the pins at ACTIVE; only these are needed later.
    typedef struct packed {
        logic             write;
        logic [COL_W-1:0] col;
        logic [DQ_W-1:0]  wdata;
        logic [DQM_W-1:0] be;
    } eng_req_t;

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Column address for READ/WRITE: A10 set selects auto-precharge.
    function automatic logic [ROW_W-1:0] col_ap_addr(input logic [COL_W-1:0] col);
        return {1'b0, 1'b1, 2'b00, col};
    endfunction

endpackage

// File: rtl/sdram_refresh_timer.sv
// rtl/sdram_refresh_timer.sv - free-running refresh interval counter with pending flag
//
// Ports:
//   dram_clk        : clock, rising edge
//   reset           : synchronous, active-high
//   enable          : counter runs only while high (init_done); held cleared otherwise
//   refresh_clear   : pulse when AUTO REFRESH is issued
//   refresh_due     : counter is at its last value; pending sets on this edge
//   refresh_pending : a refresh is owed
module sdram_refresh_timer
    import sdram_pkg::*;
#(
    parameter int REFRESH_INTERVAL = REFRESH_INTERVAL_DEF
) (
    input  logic dram_clk,
    input  logic reset,
    input  logic enable,
    input  logic refresh_clear,
    output logic refresh_due,
    output logic refresh_pending
);

    localparam int CNT_W = $clog2(REFRESH_INTERVAL);

    logic [CNT_W-1:0] count;

    assign refresh_due = enable && (count == CNT_W'(REFRESH_INTERVAL - 1));

    always_ff @(posedge dram_clk) begin
        if (reset || !enable) begin
            count           <= '0;
            refresh_pending <= 1'b0;
        end else begin
            count           <= refresh_due ? '0 : count + CNT_W'(1);
            // A new interval expiring outranks a clear on the same edge.
            refresh_pending <= refresh_due || (refresh_pending && !refresh_clear);
        end
    end

endmodule

// File: rtl/sdram_access_engine.sv
// rtl/sdram_access_engine.sv - runtime single-word SDRAM read/write and auto-refresh engine
//
// Ports:
//   dram_clk, reset       : clock and synchronous active-high reset
//   init_done             : engine runs only while the init sequencer reports ready
//   req_valid/req_ready   : client handshake; req_write, req_addr {bank,row,col},
//                           req_wdata, req_be {upper,lower} qualify the request
//   rd_valid, rd_data     : one-cycle read response
//   dram_cmd {ras_n,cas_n,we_n}, dram_addr, dram_ba, dram_dqm {udqm,ldqm},
//   dram_dq_out, dram_dq_oe : registered pad outputs
//   dram_dq_in            : pad input data
module sdram_access_engine
    import sdram_pkg::*;
#(
    parameter int T_RCD            = T_RCD_DEF,
    parameter int CAS_LATENCY      = CAS_LATENCY_DEF,
    parameter int T_RP             = T_RP_DEF,
    parameter int T_WR             = T_WR_DEF,
    parameter int T_RFC            = T_RFC_DEF,
    parameter int REFRESH_INTERVAL = REFRESH_INTERVAL_DEF
) (
    input  logic              dram_clk,
    input  logic              reset,
    input  logic              init_done,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DQ_W-1:0]   req_wdata,
    input  logic [DQM_W-1:0]  req_be,
    output logic              rd_valid,
    output logic [DQ_W-1:0]   rd_data,
    output logic [2:0]        dram_cmd,
    output logic [ROW_W-1:0]  dram_addr,
    output logic [BANK_W-1:0] dram_ba,
    output logic [DQM_W-1:0]  dram_dqm,
    output logic [DQ_W-1:0]   dram_dq_out,
    output logic              dram_dq_oe,
    input  logic [DQ_W-1:0]   dram_dq_in
);

    // Counter reload values. The state that loads a count also issues the
    // command, and the wait state leaves on the edge where the count is zero,
    // so a load of N gives N+1 NOP cycles. T_RCD and T_RFC loads are reduced
    // by one more because ACTIVE/AUTO REFRESH are issued from IDLE.
    localparam logic [WAIT_W-1:0] RCD_LOAD = WAIT_W'(T_RCD - 2);
    localparam logic [WAIT_W-1:0] WR_LOAD  = WAIT_W'(T_WR + T_RP - 1);
    localparam logic [WAIT_W-1:0] RD_LOAD  = WAIT_W'(imax(CAS_LATENCY + 1, T_RP) - 1);
    localparam logic [WAIT_W-1:0] RFC_LOAD = WAIT_W'(T_RFC - 2);

    eng_state_t             state;
    logic [WAIT_W-1:0]      wait_cnt;
    eng_req_t               req_q;
    logic [CAS_LATENCY:0]   rd_pipe;
    logic                   refresh_due;
    logic                   refresh_pending;
    logic                   refresh_clear;

    assign refresh_clear = (state == ST_IDLE) && refresh_pending;

    sdram_refresh_timer #(
        .REFRESH_INTERVAL(REFRESH_INTERVAL)
    ) u_refresh_timer (
        .dram_clk       (dram_clk),
        .reset          (reset),
        .enable         (init_done),
        .refresh_clear  (refresh_clear),
        .refresh_due    (refresh_due),
        .refresh_pending(refresh_pending)
    );

    always_ff @(posedge dram_clk) begin
        if (reset || !init_done) begin
            state       <= ST_IDLE;
            wait_cnt    <= '0;
            req_q       <= '0;
            req_ready   <= 1'b0;
            dram_cmd    <= CMD_NOP;
            dram_addr   <= '0;
            dram_ba     <= '0;
            dram_dqm    <= 2'b11;
            dram_dq_out <= '0;
            dram_dq_oe  <= 1'b0;
            rd_pipe     <= '0;
            rd_valid    <= 1'b0;
            rd_data     <= '0;
        end else begin
            dram_cmd  <= CMD_NOP;
            req_ready <= 1'b0;

            // Token enters with the READ command; at tap CAS_LATENCY the data
            // is on dram_dq_in, and rd_data doubles as the input register.
            rd_pipe  <= {rd_pipe[CAS_LATENCY-1:0], state == ST_READ};
            rd_valid <= rd_pipe[CAS_LATENCY];
            if (rd_pipe[CAS_LATENCY]) begin
                rd_data <= dram_dq_in;
            end

            case (state)
                ST_IDLE: begin
                    if (refresh_pending) begin
                        dram_cmd <= CMD_AUTO_REFRESH;
                        wait_cnt <= RFC_LOAD;
                        state    <= ST_REFRESH;
                    end else if (req_valid && req_ready) begin
                        req_q.write <= req_write;
                        req_q.col   <= req_addr[COL_W-1:0];
                        req_q.wdata <= req_wdata;
                        req_q.be    <= req_be;
                        dram_cmd    <= CMD_ACTIVE;
                        dram_ba     <= req_addr[ADDR_W-1 -: BANK_W];
                        dram_addr   <= req_addr[COL_W +: ROW_W];
                        wait_cnt    <= RCD_LOAD;
                        state       <= ST_WAIT_RCD;
                    end else begin
                        // Drop ready ahead of the pending flag so a visible
                        // handshake is never overridden by a refresh.
                        req_ready <= !refresh_due;
                    end
                end

                ST_WAIT_RCD: begin
                    if (wait_cnt == '0) begin
                        state <= req_q.write ? ST_WRITE : ST_READ;
                    end else begin
                        wait_cnt <= wait_cnt - WAIT_W'(1);
                    end
                end

                ST_WRITE: begin
                    dram_cmd    <= CMD_WRITE;
                    dram_addr   <= col_ap_addr(req_q.col);
                    dram_dq_oe  <= 1'b1;
                    dram_dq_out <= req_q.wdata;
                    dram_dqm    <= ~req_q.be;
                    wait_cnt    <= WR_LOAD;
                    state       <= ST_WRITE_REC;
                end

                ST_WRITE_REC: begin
                    dram_dq_oe <= 1'b0;
                    dram_dqm   <= 2'b11;
                    if (wait_cnt == '0) begin
                        state <= ST_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt - WAIT_W'(1);
                    end
                end

                ST_READ: begin
                    dram_cmd  <= CMD_READ;
                    dram_addr <= col_ap_addr(req_q.col);
                    dram_dqm  <= 2'b00;
                    wait_cnt  <= RD_LOAD;
                    state     <= ST_READ_WAIT;
                end

                ST_READ_WAIT: begin
                    // DQM stays low until the read data has passed the pins.
                    if (wait_cnt == '0) begin
                        dram_dqm <= 2'b11;
                        state    <= ST_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt - WAIT_W'(1);
                    end
                end

                ST_REFRESH: begin
                    if (wait_cnt == '0) begin
                        state <= ST_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt - WAIT_W'(1);
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
